// File: rtl/ex_stage_if.sv
// Decode-to-execute bus for ex_stage: operation, operands and destination in,
// ALU result, HI/LO write-back and pipeline stall request out.
interface ex_stage_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        annul_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;
    logic        stallreq_o;

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
        output wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq_o
    );

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, annul_i,
        input  wd_o, wreg_o, wdata_o, hi_o, lo_o, whilo_o, stallreq_o
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: combinational logic/shift ALU plus an optional multi-cycle
// restoring divider, enabled by defining DIV_EN.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    logic        is_div_s;
    logic [31:0] alu_res_s;

    assign is_div_s    = (bus.aluop_i == EXE_DIV_OP) || (bus.aluop_i == EXE_DIVU_OP);
    assign bus.wd_o    = bus.wd_i;
    assign bus.wreg_o  = bus.wreg_i;
    assign bus.wdata_o = (rst && !is_div_s) ? alu_res_s : 32'h0000_0000;

    // Logic and shift result selection; anything unrecognised yields zero
    always_comb begin
        alu_res_s = 32'h0000_0000;
        case (bus.alusel_i)
            EXE_RES_LOGIC: begin
                case (bus.aluop_i)
                    EXE_OR_OP:  alu_res_s = bus.reg1_i | bus.reg2_i;
                    EXE_AND_OP: alu_res_s = bus.reg1_i & bus.reg2_i;
                    EXE_XOR_OP: alu_res_s = bus.reg1_i ^ bus.reg2_i;
                    EXE_NOR_OP: alu_res_s = ~(bus.reg1_i | bus.reg2_i);
                    default:    alu_res_s = 32'h0000_0000;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (bus.aluop_i)
                    EXE_SLL_OP: alu_res_s = bus.reg2_i << bus.reg1_i[4:0];
                    EXE_SRL_OP: alu_res_s = bus.reg2_i >> bus.reg1_i[4:0];
                    EXE_SRA_OP: alu_res_s = 32'($signed(bus.reg2_i) >>> bus.reg1_i[4:0]);
                    default:    alu_res_s = 32'h0000_0000;
                endcase
            end
            EXE_RES_NOP: alu_res_s = 32'h0000_0000;
            default:     alu_res_s = 32'h0000_0000;
        endcase
    end

`ifdef DIV_EN
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } div_state_e;

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        is_signed_s;
    logic [31:0] abs_a_s, abs_b_s;
    logic [32:0] partial_s, trial_s;
    logic [31:0] step_rem_s, step_quo_s;

    assign is_signed_s = (bus.aluop_i == EXE_DIV_OP);
    assign abs_a_s = (is_signed_s && bus.reg1_i[31]) ? (32'h0000_0000 - bus.reg1_i) : bus.reg1_i;
    assign abs_b_s = (is_signed_s && bus.reg2_i[31]) ? (32'h0000_0000 - bus.reg2_i) : bus.reg2_i;

    // Quotient register doubles as the dividend shifter: its MSB feeds the remainder each step
    assign partial_s  = {rem_q, quo_q[31]};
    assign trial_s    = partial_s - {1'b0, divisor_q};
    assign step_rem_s = trial_s[32] ? partial_s[31:0] : trial_s[31:0];
    assign step_quo_s = {quo_q[30:0], ~trial_s[32]};

    // Divider state and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= 6'd0;
            divisor_q <= 32'h0000_0000;
            rem_q     <= 32'h0000_0000;
            quo_q     <= 32'h0000_0000;
            hi_q      <= 32'h0000_0000;
            lo_q      <= 32'h0000_0000;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Divider next-state and datapath control
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (bus.annul_i) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (is_div_s) begin
                        if (bus.reg2_i == 32'h0000_0000) begin
                            state_d = DIV_ZERO;
                        end else begin
                            divisor_d = abs_b_s;
                            quo_d     = abs_a_s;
                            rem_d     = 32'h0000_0000;
                            cnt_d     = 6'd0;
                            neg_quo_d = is_signed_s & (bus.reg1_i[31] ^ bus.reg2_i[31]);
                            neg_rem_d = is_signed_s & bus.reg1_i[31];
                            state_d   = DIV_ON;
                        end
                    end else begin
                        state_d = DIV_IDLE;
                    end
                end
                DIV_ZERO: begin
                    hi_d    = 32'h0000_0000;
                    lo_d    = 32'h0000_0000;
                    state_d = DIV_END;
                end
                DIV_ON: begin
                    rem_d = step_rem_s;
                    quo_d = step_quo_s;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_CYCLES - 1)) begin
                        hi_d    = neg_rem_q ? (32'h0000_0000 - step_rem_s) : step_rem_s;
                        lo_d    = neg_quo_q ? (32'h0000_0000 - step_quo_s) : step_quo_s;
                        state_d = DIV_END;
                    end else begin
                        state_d = DIV_ON;
                    end
                end
                DIV_END: state_d = DIV_IDLE;
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    assign bus.hi_o       = hi_q;
    assign bus.lo_o       = lo_q;
    assign bus.whilo_o    = (state_q == DIV_END) && !bus.annul_i;
    assign bus.stallreq_o = rst && is_div_s && (state_q != DIV_END) && !bus.annul_i;
`else
    logic div_unused_s;

    assign div_unused_s   = clk ^ bus.annul_i;
    assign bus.hi_o       = 32'h0000_0000;
    assign bus.lo_o       = 32'h0000_0000;
    assign bus.whilo_o    = 1'b0;
    assign bus.stallreq_o = 1'b0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: ALU vectors, divider scoreboard, annul and
// mid-divide reset; divider expectations follow the DIV_EN build option.
module tb_ex_stage;
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    typedef struct {
        string       tag;
        logic [31:0] lo;
        logic [31:0] hi;
    } div_exp_t;

    logic        clk;
    logic        rst;
    int          n_tests;
    int          n_fail;
    logic [31:0] last_lo;
    logic [31:0] last_hi;
    div_exp_t    div_q[$];
    logic [31:0] alu_q[$];

    ex_stage_if bus ();

    ex_stage #(.DIV_CYCLES(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void div_model(input logic is_signed, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] q,
                                      output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'h0) begin
            q = 32'h0;
            r = 32'h0;
        end else begin
            if (is_signed) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'h0, a});
                sb = longint'({32'h0, b});
            end
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endfunction

    // Tasks start and end just after a rising edge; outputs are sampled on the falling edge
    task automatic run_alu(input string tag, input logic [7:0] op, input logic [2:0] sel,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        logic [4:0] wd;
        logic       wr;
        wd = 5'($urandom_range(0, 31));
        wr = 1'($urandom_range(0, 1));
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
        bus.wd_i     = wd;
        bus.wreg_i   = wr;
        alu_q.push_back(exp);
        @(negedge clk);
        check_eq({tag, "_wdata"}, bus.wdata_o, alu_q.pop_front());
        check_eq({tag, "_stall"}, 32'(bus.stallreq_o), 32'h0);
        check_eq({tag, "_wd"}, 32'(bus.wd_o), 32'(wd));
        check_eq({tag, "_wreg"}, 32'(bus.wreg_o), 32'(wr));
        check_eq({tag, "_hi_hold"}, bus.hi_o, last_hi);
        check_eq({tag, "_lo_hold"}, bus.lo_o, last_lo);
        @(posedge clk); #1;
    endtask

    task automatic run_div(input string tag, input logic is_signed,
                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        div_exp_t    e;
        int          stalls;
        bit          done;
        div_model(is_signed, a, b, q, r);
        bus.aluop_i  = is_signed ? EXE_DIV_OP : EXE_DIVU_OP;
        bus.alusel_i = EXE_RES_NOP;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
`ifdef DIV_EN
        e.tag = tag;
        e.lo  = q;
        e.hi  = r;
        div_q.push_back(e);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (bus.whilo_o) begin
                e = div_q.pop_front();
                check_eq({e.tag, "_lo"}, bus.lo_o, e.lo);
                check_eq({e.tag, "_hi"}, bus.hi_o, e.hi);
                check_eq({e.tag, "_stall_end"}, 32'(bus.stallreq_o), 32'h0);
                check_eq({e.tag, "_wdata"}, bus.wdata_o, 32'h0);
                check_eq({e.tag, "_stall_cycles"}, 32'(stalls), (b == 32'h0) ? 32'd2 : 32'd33);
                done = 1'b1;
            end else begin
                if (bus.stallreq_o) stalls++;
                @(posedge clk); #1;
            end
        end
        check_eq({tag, "_completed"}, 32'(done), 32'h1);
        last_lo = q;
        last_hi = r;
        @(posedge clk); #1;
        bus.aluop_i = EXE_NOP_OP;
        @(negedge clk);
        check_eq({tag, "_whilo_one_cycle"}, 32'(bus.whilo_o), 32'h0);
        check_eq({tag, "_lo_held"}, bus.lo_o, last_lo);
        @(posedge clk); #1;
`else
        @(negedge clk);
        check_eq({tag, "_stall_off"}, 32'(bus.stallreq_o), 32'h0);
        check_eq({tag, "_whilo_off"}, 32'(bus.whilo_o), 32'h0);
        check_eq({tag, "_hi_off"}, bus.hi_o, 32'h0);
        check_eq({tag, "_lo_off"}, bus.lo_o, 32'h0);
        check_eq({tag, "_wdata_off"}, bus.wdata_o, 32'h0);
        @(posedge clk); #1;
        bus.aluop_i = EXE_NOP_OP;
`endif
    endtask

    task automatic watch_no_whilo(input string tag);
        int pulses;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.whilo_o) pulses++;
            @(posedge clk); #1;
        end
        check_eq({tag, "_no_whilo"}, 32'(pulses), 32'h0);
        check_eq({tag, "_hi"}, bus.hi_o, last_hi);
        check_eq({tag, "_lo"}, bus.lo_o, last_lo);
    endtask

    task automatic run_annul();
        bus.aluop_i  = EXE_DIVU_OP;
        bus.alusel_i = EXE_RES_NOP;
        bus.reg1_i   = 32'd1000;
        bus.reg2_i   = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        bus.annul_i = 1'b1;
        @(negedge clk);
        check_eq("annul_stall", 32'(bus.stallreq_o), 32'h0);
        check_eq("annul_whilo", 32'(bus.whilo_o), 32'h0);
        @(posedge clk); #1;
        bus.annul_i = 1'b0;
        bus.aluop_i = EXE_NOP_OP;
        watch_no_whilo("annul");
    endtask

    task automatic run_reset();
        bus.aluop_i  = EXE_DIVU_OP;
        bus.alusel_i = EXE_RES_NOP;
        bus.reg1_i   = 32'd12345;
        bus.reg2_i   = 32'd7;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_hi", bus.hi_o, 32'h0);
        check_eq("midrst_lo", bus.lo_o, 32'h0);
        check_eq("midrst_stall", 32'(bus.stallreq_o), 32'h0);
        check_eq("midrst_whilo", 32'(bus.whilo_o), 32'h0);
        check_eq("midrst_wdata", bus.wdata_o, 32'h0);
        @(posedge clk); #1;
        rst         = 1'b1;
        bus.aluop_i = EXE_NOP_OP;
        last_lo     = 32'h0;
        last_hi     = 32'h0;
        watch_no_whilo("midrst");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        last_lo      = 32'h0;
        last_hi      = 32'h0;
        rst          = 1'b0;
        bus.aluop_i  = EXE_OR_OP;
        bus.alusel_i = EXE_RES_LOGIC;
        bus.reg1_i   = 32'h0000_FFFF;
        bus.reg2_i   = 32'hFFFF_0000;
        bus.wd_i     = 5'd0;
        bus.wreg_i   = 1'b0;
        bus.annul_i  = 1'b0;
        #2;
        check_eq("rst_hi", bus.hi_o, 32'h0);
        check_eq("rst_lo", bus.lo_o, 32'h0);
        check_eq("rst_whilo", 32'(bus.whilo_o), 32'h0);
        check_eq("rst_stall", 32'(bus.stallreq_o), 32'h0);
        check_eq("rst_wdata", bus.wdata_o, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        run_alu("or_spec",  EXE_OR_OP,  EXE_RES_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF, 32'h00FF_F0FF);
        run_alu("and",      EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        run_alu("xor",      EXE_XOR_OP, EXE_RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        run_alu("nor",      EXE_NOR_OP, EXE_RES_LOGIC, 32'h0F0F_0000, 32'h0000_0F0F, 32'hF0F0_F0F0);
        run_alu("sll",      EXE_SLL_OP, EXE_RES_SHIFT, 32'd8,         32'h0000_00AB, 32'h0000_AB00);
        run_alu("sll31",    EXE_SLL_OP, EXE_RES_SHIFT, 32'd31,        32'h0000_0001, 32'h8000_0000);
        run_alu("srl",      EXE_SRL_OP, EXE_RES_SHIFT, 32'd4,         32'h8000_0000, 32'h0800_0000);
        run_alu("sra_spec", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4,         32'h8000_0000, 32'hF800_0000);
        run_alu("sra_low5", EXE_SRA_OP, EXE_RES_SHIFT, 32'h0000_0024, 32'h7000_0000, 32'h0700_0000);
        run_alu("nop_sel",  EXE_OR_OP,  EXE_RES_NOP,   32'h1234_5678, 32'h0F0F_0F0F, 32'h0000_0000);
        run_alu("bad_sel",  EXE_OR_OP,  3'b111,        32'h1234_5678, 32'h0F0F_0F0F, 32'h0000_0000);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7);
`ifdef DIV_EN
        check_eq("divu_spec_lo", bus.lo_o, 32'd14);
        check_eq("divu_spec_hi", bus.hi_o, 32'd2);
`endif
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
`ifdef DIV_EN
        check_eq("div_spec_lo", bus.lo_o, 32'hFFFF_FFFD);
        check_eq("div_spec_hi", bus.hi_o, 32'hFFFF_FFFF);
`endif
        run_div("div_5_0",      1'b1, 32'd5,         32'd0);
        run_div("div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_div("divu_max_1",   1'b0, 32'hFFFF_FFFF, 32'd1);
        run_div("divu_small",   1'b0, 32'd3,         32'd10);
        run_div("div_m100_7",   1'b1, 32'hFFFF_FF9C, 32'd7);
        run_div("div_100_m7",   1'b1, 32'd100,       32'hFFFF_FFF9);
        run_div("divu_big",     1'b0, 32'hFFFF_FFF0, 32'h8000_0001);
        for (int i = 0; i < 3; i++) begin
            run_div($sformatf("div_rand%0d", i),  1'b1, $urandom, $urandom_range(1, 32'h7FFF));
            run_div($sformatf("divu_rand%0d", i), 1'b0, $urandom, $urandom);
        end
        run_alu("or_after_div", EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_0001, 32'h0000_0100, 32'h0000_0101);

        run_annul();
        run_div("div_pre_rst", 1'b0, 32'd77, 32'd5);
        run_reset();
        run_div("divu_81_9", 1'b0, 32'd81, 32'd9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
